// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the mux_rr_arbiter slice: state encoding, widths and
// a one-hot helper used by the arbiter top.
package mux_rr_arbiter_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned TEN_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // One-hot decode of a source index.
    function automatic logic [N_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick4.sv
// rr_pick4: combinational round-robin picker.
// Ports:
//   req [3:0] - request vector
//   ptr [1:0] - highest-priority index; search order ptr, ptr+1, ... mod 4
//   any       - at least one request set
//   win [1:0] - first requesting index in search order (ptr when none)
module rr_pick4
    import mux_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] win
);

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [SEL_W-1:0]   w_off;

    // Rotate so that bit 0 of w_rot is the request at ptr.
    assign w_dbl = {req, req};
    assign w_rot = N_REQ'(w_dbl >> ptr);
    assign any   = |req;

    // Lowest set bit of the rotated vector is the offset from ptr.
    always_comb begin
        w_off = '0;
        casez (w_rot)
            4'b???1: w_off = 2'd0;
            4'b??10: w_off = 2'd1;
            4'b?100: w_off = 2'd2;
            4'b1000: w_off = 2'd3;
            default: w_off = 2'd0;
        endcase
    end

    assign win = SEL_W'(ptr + w_off);

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter sharing a 4:1 mux output between four
// requesters, with a bounded tenure (MAX_HOLD) per owner.
// Optional build macro: MUX_ARB_PRIO0_EN (source 0 pre-empts and is unbounded).
// Ports:
//   clk, rst_n      - clock, async active-low reset
//   req [3:0]       - per-source request, held until granted
//   i0..i3 [DW-1:0] - source data
//   grant [3:0]     - one-hot owner (registered), 0 when idle
//   s1, s0          - registered mux select
//   valid           - an owner holds the channel (registered)
//   y [DW-1:0]      - selected data when valid, else 0 (combinational)
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int unsigned DW       = 1,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [DW-1:0]    i0,
    input  logic [DW-1:0]    i1,
    input  logic [DW-1:0]    i2,
    input  logic [DW-1:0]    i3,
    output logic [N_REQ-1:0] grant,
    output logic             s1,
    output logic             s0,
    output logic             valid,
    output logic [DW-1:0]    y
);

    state_t           r_state;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] r_sel;
    logic [TEN_W-1:0] r_tenure;
    logic [N_REQ-1:0] r_grant;
    logic             r_valid;

    logic             w_owner_req;
    logic             w_expire;
    logic             w_release;
    logic             w_ptr_adv;
    logic [SEL_W-1:0] w_ptr_next;
    logic             w_any;
    logic [SEL_W-1:0] w_pick;
    logic [SEL_W-1:0] w_win;

    assign w_owner_req = req[r_sel];
    assign w_expire    = (r_tenure == TEN_W'(MAX_HOLD));

    // Release decision for the current owner; only meaningful in GRANT.
    always_comb begin
        w_release = 1'b0;
        w_ptr_adv = 1'b0;
        if (r_state == ST_GRANT) begin
`ifdef MUX_ARB_PRIO0_EN
            if (r_sel == '0) begin
                w_release = !req[0];
                w_ptr_adv = 1'b0;
            end else begin
                w_release = !w_owner_req || w_expire || req[0];
                w_ptr_adv = w_release;
            end
`else
            w_release = !w_owner_req || w_expire;
            w_ptr_adv = w_release;
`endif
        end
    end

    // On release the owner moves to the back of the search order.
    assign w_ptr_next = w_ptr_adv ? SEL_W'(r_sel + 2'd1) : r_ptr;

    rr_pick4 u_pick (
        .req (req),
        .ptr (w_ptr_next),
        .any (w_any),
        .win (w_pick)
    );

`ifdef MUX_ARB_PRIO0_EN
    assign w_win = req[0] ? '0 : w_pick;
`else
    assign w_win = w_pick;
`endif

    // Arbitration FSM with registered grant/select/valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_sel    <= '0;
            r_tenure <= '0;
            r_grant  <= '0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state  <= ST_GRANT;
                        r_sel    <= w_win;
                        r_grant  <= onehot4(w_win);
                        r_valid  <= 1'b1;
                        r_tenure <= TEN_W'(1);
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_ptr <= w_ptr_next;
                        if (w_any) begin
                            // Back-to-back handover, no idle cycle.
                            r_sel    <= w_win;
                            r_grant  <= onehot4(w_win);
                            r_tenure <= TEN_W'(1);
                        end else begin
                            // Select keeps its last value while idle.
                            r_state  <= ST_IDLE;
                            r_grant  <= '0;
                            r_valid  <= 1'b0;
                            r_tenure <= '0;
                        end
                    end else begin
                        r_tenure <= TEN_W'(r_tenure + TEN_W'(1));
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign grant = r_grant;
    assign s1    = r_sel[1];
    assign s0    = r_sel[0];
    assign valid = r_valid;

    // Output mux driven from the registered select.
    always_comb begin
        y = '0;
        if (r_valid) begin
            case (r_sel)
                2'd0:    y = i0;
                2'd1:    y = i1;
                2'd2:    y = i2;
                default: y = i3;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Testbench for mux_rr_arbiter: directed scenarios followed by random traffic,
// checked against a queue-free behavioural model of owner/pointer/tenure.
module tb_mux_rr_arbiter;

    localparam int DW       = 1;
    localparam int MAX_HOLD = 4;
`ifdef MUX_ARB_PRIO0_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req;
    logic [DW-1:0] i0, i1, i2, i3;
    logic [3:0]    grant;
    logic          s1, s0, valid;
    logic [DW-1:0] y;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: owner index (-1 idle), priority pointer, tenure, last select.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_ten   = 0;
    int m_sel   = 0;

    mux_rr_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .i0    (i0),
        .i1    (i1),
        .i2    (i2),
        .i3    (i3),
        .grant (grant),
        .s1    (s1),
        .s0    (s0),
        .valid (valid),
        .y     (y)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] r, input int p);
        if (PRIO && r[0]) return 0;
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_ten   = 0;
        m_sel   = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        int w;
        bit rel;
        if (m_owner < 0) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_sel = w; m_ten = 1;
            end
        end else begin
            if (PRIO && m_owner == 0) rel = !r[0];
            else rel = !r[m_owner] || (m_ten == MAX_HOLD) || (PRIO && r[0]);
            if (rel) begin
                if (!(PRIO && m_owner == 0)) m_ptr = (m_owner + 1) % 4;
                w = pick(r, m_ptr);
                if (w >= 0) begin
                    m_owner = w; m_sel = w; m_ten = 1;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_ten++;
            end
        end
    endtask

    function automatic logic [DW-1:0] exp_y();
        if (m_owner < 0) return '0;
        case (m_sel)
            0:       return i0;
            1:       return i1;
            2:       return i2;
            default: return i3;
        endcase
    endfunction

    task automatic check(input string tag);
        logic [3:0]    eg;
        logic [1:0]    es;
        logic [DW-1:0] ey;
        eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        es = 2'(m_sel);
        ey = exp_y();
        n_tests++;
        assert (grant === eg) else begin
            n_fail++;
            $error("FAIL %s grant got %b exp %b", tag, grant, eg);
        end
        n_tests++;
        assert (valid === (m_owner >= 0)) else begin
            n_fail++;
            $error("FAIL %s valid got %b exp %b", tag, valid, (m_owner >= 0));
        end
        n_tests++;
        assert ({s1, s0} === es) else begin
            n_fail++;
            $error("FAIL %s sel got %b exp %b", tag, {s1, s0}, es);
        end
        n_tests++;
        assert (y === ey) else begin
            n_fail++;
            $error("FAIL %s y got %b exp %b", tag, y, ey);
        end
    endtask

    // One clock: DUT and model see the same pre-edge inputs, then compare.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_step(req);
        #1;
        check(tag);
    endtask

    task automatic expect4(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got %b exp %b", tag, got, exp);
        end
    endtask

    initial begin
        logic [3:0] rot_exp;

        // Reset held with all requests asserted.
        rst_n = 1'b0;
        req   = 4'b1111;
        i0 = '0; i1 = '0; i2 = '0; i3 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset");
        rst_n = 1'b1;
        i0 = 1'b1;
        cycle("rst_release");
        expect4("first_grant", grant, 4'b0001);

        // Steady all-request rotation with MAX_HOLD tenures.
        for (int c = 1; c < 20; c++) begin
            i0 = DW'($urandom); i1 = DW'($urandom); i2 = DW'($urandom); i3 = DW'($urandom);
            cycle("rotation");
            rot_exp = PRIO ? 4'b0001 : 4'(1 << ((c / MAX_HOLD) % 4));
            expect4("rotation_seq", grant, rot_exp);
        end

        // Early release by source 2, then ptr=3 search order.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("reset2");
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b0100;
        cycle("early_g1");
        cycle("early_g2");
        req = 4'b0000;
        cycle("early_drop");
        expect4("early_idle", {3'b000, valid}, 4'b0000);
        req = 4'b0011;
        cycle("ptr3_pick");
        expect4("ptr3_grant", grant, 4'b0001);

        // Data path from source 1 with unknowns on the other inputs.
        req = 4'b0010;
        i0 = 'x; i2 = 'x; i3 = 'x; i1 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cycle("datapath");
            n_tests++;
            assert (y === i1) else begin
                n_fail++;
                $error("FAIL datapath_y got %b exp %b", y, i1);
            end
            i1 = ~i1;
        end
        i0 = '0; i1 = '0; i2 = '0; i3 = '0;

        // Solo requester re-wins through repeated tenure expiry.
        req = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            cycle("solo");
            expect4("solo_grant", grant, 4'b0100);
        end

        // Asynchronous reset while source 1 owns the channel.
        req = 4'b0010;
        cycle("pre_async");
        expect4("pre_async_grant", grant, 4'b0010);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MUX_ARB_PRIO0_EN
        // Source 0 pre-empts source 3 and is not limited by MAX_HOLD.
        req = 4'b1000;
        cycle("prio_s3");
        expect4("prio_s3_grant", grant, 4'b1000);
        req = 4'b1001;
        for (int c = 0; c < 8; c++) begin
            cycle("prio_s0");
            expect4("prio_s0_grant", grant, 4'b0001);
        end
`endif

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            req = 4'($urandom);
            i0 = DW'($urandom); i1 = DW'($urandom); i2 = DW'($urandom); i3 = DW'($urandom);
            cycle("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
